rx_da_filter_ctrl: RTL and testbench

//  Receive-path stage that sits directly upstream of the DA checker and also consumes its results.
//  It extracts the 48-bit destination address from the first data word of each frame and drives it as da_addr.
//  One cycle later it samples the checker flags and produces a per-frame accept/drop decision.
//  It also keeps a saturating count of dropped frames.

---
 rtl/rx_da_filter_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rx_da_filter_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_da_filter_ctrl.sv
// Receive-path DA filter control: captures the destination address from the sof word,
// registers the DA checker's verdict one cycle later and keeps a saturating drop counter.
module rx_da_filter_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rxclk,
    input  logic                 reset,
    input  logic [63:0]          data_in,
    input  logic                 data_valid,
    input  logic                 sof,
    input  logic                 eof,
    input  logic                 cfg_promisc,
    input  logic                 cfg_bcast_en,
    input  logic                 cfg_mcast_en,
    input  logic                 clr_count,
    input  logic                 local_invalid,
    input  logic                 broad_valid,
    input  logic                 multi_valid,
    output logic [47:0]          da_addr,
    output logic                 da_check_valid,
    output logic                 frame_accept,
    output logic                 frame_drop,
    output logic                 frame_is_bcast,
    output logic                 frame_is_mcast,
    output logic                 frame_abort,
    output logic [CNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACTIVE = 2'd2,
        DONE1  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 eof_seen_q, eof_seen_d;
    logic [47:0]          da_addr_q, da_addr_d;
    logic                 accept_q, accept_d;
    logic                 drop_q, drop_d;
    logic                 bcast_q, bcast_d;
    logic                 mcast_q, mcast_d;
    logic                 check_valid_q, check_valid_d;
    logic                 abort_q, abort_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic                 sof_hit;
    logic                 eof_hit;
    logic                 accept_now;
    logic                 count_inc;
    logic [47:0]          da_wire;

    assign sof_hit    = sof & data_valid;
    assign eof_hit    = eof & data_valid;
    assign accept_now = cfg_promisc | ~local_invalid
                      | (broad_valid & cfg_bcast_en)
                      | (multi_valid & cfg_mcast_en);

    // First octet on the wire becomes the most significant byte of the address
    assign da_wire = {data_in[7:0],   data_in[15:8],  data_in[23:16],
                      data_in[31:24], data_in[39:32], data_in[47:40]};

    always_comb begin
        state_d       = state_q;
        eof_seen_d    = eof_seen_q;
        da_addr_d     = da_addr_q;
        accept_d      = accept_q;
        drop_d        = drop_q;
        bcast_d       = bcast_q;
        mcast_d       = mcast_q;
        check_valid_d = 1'b0;
        abort_d       = 1'b0;
        count_inc     = 1'b0;

        // A new sof always restarts the frame; outside IDLE it also aborts the open one
        if (sof_hit) begin
            da_addr_d  = da_wire;
            eof_seen_d = eof;
            state_d    = CHECK;
            accept_d   = 1'b0;
            drop_d     = 1'b0;
            bcast_d    = 1'b0;
            mcast_d    = 1'b0;
            abort_d    = (state_q != IDLE);
        end else begin
            case (state_q)
                IDLE: begin
                end
                CHECK: begin
                    accept_d      = accept_now;
                    drop_d        = ~accept_now;
                    bcast_d       = broad_valid;
                    mcast_d       = multi_valid;
                    check_valid_d = 1'b1;
                    count_inc     = ~accept_now;
                    eof_seen_d    = eof_seen_q | eof_hit;
                    state_d       = (eof_seen_q | eof_hit) ? DONE1 : ACTIVE;
                end
                ACTIVE: begin
                    if (eof_hit) begin
                        accept_d = 1'b0;
                        drop_d   = 1'b0;
                        bcast_d  = 1'b0;
                        mcast_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end
                DONE1: begin
                    accept_d = 1'b0;
                    drop_d   = 1'b0;
                    bcast_d  = 1'b0;
                    mcast_d  = 1'b0;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        drop_count_d = drop_count_q;
        if (clr_count) begin
            drop_count_d = '0;
        end else if (count_inc && (drop_count_q != {CNT_WIDTH{1'b1}})) begin
            drop_count_d = drop_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q       <= IDLE;
            eof_seen_q    <= 1'b0;
            da_addr_q     <= '0;
            accept_q      <= 1'b0;
            drop_q        <= 1'b0;
            bcast_q       <= 1'b0;
            mcast_q       <= 1'b0;
            check_valid_q <= 1'b0;
            abort_q       <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            eof_seen_q    <= eof_seen_d;
            da_addr_q     <= da_addr_d;
            accept_q      <= accept_d;
            drop_q        <= drop_d;
            bcast_q       <= bcast_d;
            mcast_q       <= mcast_d;
            check_valid_q <= check_valid_d;
            abort_q       <= abort_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign da_addr        = da_addr_q;
    assign da_check_valid = check_valid_q;
    assign frame_accept   = accept_q;
    assign frame_drop     = drop_q;
    assign frame_is_bcast = bcast_q;
    assign frame_is_mcast = mcast_q;
    assign frame_abort    = abort_q;
    assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_rx_da_filter_ctrl.sv
// Bench for rx_da_filter_ctrl: directed scenarios followed by random frames checked
// against a frame-timeline reference model.
module tb_rx_da_filter_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int N    = 2000;

    logic          rxclk;
    logic          reset;
    logic [63:0]   data_in;
    logic          data_valid, sof, eof;
    logic          cfg_promisc, cfg_bcast_en, cfg_mcast_en, clr_count;
    logic          local_invalid, broad_valid, multi_valid;
    logic [47:0]   da_addr;
    logic          da_check_valid, frame_accept, frame_drop;
    logic          frame_is_bcast, frame_is_mcast, frame_abort;
    logic [CW-1:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt;

    typedef struct packed {
        logic        sof, eof, dv, li, bv, mv, pr, bce, mce, clr;
        logic [63:0] data;
    } stim_t;

    typedef struct packed {
        logic [47:0] da;
        logic        cv, acc, drp, bc, mc, ab, inc;
    } exp_t;

    stim_t       st[N];
    exp_t        ex[N];
    logic        ld[N];
    logic [47:0] ldval[N];
    int          ecnt[N];
    int          ncyc;

    rx_da_filter_ctrl #(.CNT_WIDTH(CW)) dut (
        .rxclk          (rxclk),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .sof            (sof),
        .eof            (eof),
        .cfg_promisc    (cfg_promisc),
        .cfg_bcast_en   (cfg_bcast_en),
        .cfg_mcast_en   (cfg_mcast_en),
        .clr_count      (clr_count),
        .local_invalid  (local_invalid),
        .broad_valid    (broad_valid),
        .multi_valid    (multi_valid),
        .da_addr        (da_addr),
        .da_check_valid (da_check_valid),
        .frame_accept   (frame_accept),
        .frame_drop     (frame_drop),
        .frame_is_bcast (frame_is_bcast),
        .frame_is_mcast (frame_is_mcast),
        .frame_abort    (frame_abort),
        .drop_count     (drop_count)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    function automatic logic [47:0] da_of(input logic [63:0] d);
        logic [47:0] r;
        r = '0;
        for (int b = 0; b < 6; b++) r[47-8*b -: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic idle_inputs();
        data_in       = '0;
        data_valid    = 1'b0;
        sof           = 1'b0;
        eof           = 1'b0;
        cfg_promisc   = 1'b0;
        cfg_bcast_en  = 1'b0;
        cfg_mcast_en  = 1'b0;
        clr_count     = 1'b0;
        local_invalid = 1'b0;
        broad_valid   = 1'b0;
        multi_valid   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_decision(input string tag, input logic cv, input logic acc,
                                  input logic drp, input logic bc, input logic mc, input logic ab);
        check_val({tag, ".cv"},    da_check_valid, cv);
        check_val({tag, ".acc"},   frame_accept,   acc);
        check_val({tag, ".drop"},  frame_drop,     drp);
        check_val({tag, ".bcast"}, frame_is_bcast, bc);
        check_val({tag, ".mcast"}, frame_is_mcast, mc);
        check_val({tag, ".abort"}, frame_abort,    ab);
    endtask

    // Single-word frame whose verdict depends only on local_invalid; optional clear around the verdict
    task automatic send_single(input logic li_v, input logic clr_v);
        idle_inputs();
        sof = 1'b1; eof = 1'b1; data_valid = 1'b1;
        data_in = {$urandom, $urandom};
        tick();
        idle_inputs();
        local_invalid = li_v;
        clr_count     = clr_v;
        tick();
        idle_inputs();
        clr_count = clr_v;
        tick();
        idle_inputs();
    endtask

    // Builds random frames and the expected per-cycle outputs from frame-level timing rules
    task automatic build_random(output int n_out);
        int   p, t, s, e, vis_end;
        logic single, do_abort, abort_next, acc;
        int   c;
        logic [47:0] cur;
        for (int i = 0; i < N; i++) begin
            st[i].sof  = 1'b0;
            st[i].dv   = ($urandom_range(0, 3) != 0);
            st[i].eof  = ($urandom_range(0, 3) == 0);
            st[i].li   = 1'($urandom_range(0, 1));
            st[i].bv   = 1'($urandom_range(0, 1));
            st[i].mv   = 1'($urandom_range(0, 1));
            st[i].pr   = ($urandom_range(0, 7) == 0);
            st[i].bce  = 1'($urandom_range(0, 1));
            st[i].mce  = 1'($urandom_range(0, 1));
            st[i].clr  = 1'b0;
            st[i].data = {$urandom, $urandom};
            ex[i]      = '0;
            ld[i]      = 1'b0;
            ldval[i]   = '0;
        end
        p = 1;
        abort_next = 1'b0;
        while (p < N - 40 || abort_next) begin
            if (!abort_next) begin
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 5) == 0) st[p].clr = 1'b1;
                    p++;
                end
            end
            t = p;
            st[t].sof = 1'b1;
            st[t].dv  = 1'b1;
            single    = !abort_next && ($urandom_range(0, 3) == 0);
            st[t].eof = single;
            ex[t+1].ab = abort_next;
            ld[t+1]    = 1'b1;
            ldval[t+1] = da_of(st[t].data);
            do_abort = !single && (p < N - 40) && ($urandom_range(0, 4) == 0);
            if (single) begin
                vis_end    = t + 2;
                p          = t + 3;
                abort_next = 1'b0;
            end else if (do_abort) begin
                s = t + 1 + $urandom_range(0, 3);
                for (int k = t + 1; k < s; k++) if (st[k].dv) st[k].eof = 1'b0;
                vis_end    = s;
                p          = s;
                abort_next = 1'b1;
            end else begin
                e = t + 1 + $urandom_range(0, 4);
                for (int k = t + 1; k < e; k++) if (st[k].dv) st[k].eof = 1'b0;
                st[e].dv   = 1'b1;
                st[e].eof  = 1'b1;
                vis_end    = (e == t + 1) ? t + 2 : e;
                p          = vis_end + 1;
                abort_next = 1'b0;
            end
            if (vis_end >= t + 2) begin
                acc = st[t+1].pr | ~st[t+1].li | (st[t+1].bv & st[t+1].bce) | (st[t+1].mv & st[t+1].mce);
                for (int v = t + 2; v <= vis_end; v++) begin
                    ex[v].acc = acc;
                    ex[v].drp = ~acc;
                    ex[v].bc  = st[t+1].bv;
                    ex[v].mc  = st[t+1].mv;
                end
                ex[t+2].cv  = 1'b1;
                ex[t+2].inc = ~acc;
            end
        end
        n_out = p + 2;
        cur = '0;
        c   = 0;
        for (int i = 0; i < n_out; i++) begin
            if (ld[i]) cur = ldval[i];
            ex[i].da = cur;
            if (i > 0) begin
                if (st[i-1].clr) c = 0;
                else if (ex[i].inc && c != CMAX) c++;
            end
            ecnt[i] = c;
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        // Reset state
        do_reset();
        check_val("rst.da", da_addr, 48'h0);
        check_decision("rst", 0, 0, 0, 0, 0, 0);
        check_val("rst.cnt", drop_count, 0);
        exp_cnt = 0;

        // Unicast match: DA 00:11:22:33:44:55 accepted
        sof = 1'b1; data_valid = 1'b1; data_in = 64'h0000_5544_3322_1100;
        tick();
        check_val("t1.da", da_addr, 48'h0011_2233_4455);
        check_val("t1.cv_early", da_check_valid, 1'b0);
        idle_inputs(); data_valid = 1'b1;
        tick();
        check_decision("t1", 1, 1, 0, 0, 0, 0);
        check_val("t1.cnt", drop_count, exp_cnt);
        idle_inputs(); data_valid = 1'b1; eof = 1'b1;
        tick();
        check_decision("t1.end", 0, 0, 0, 0, 0, 0);

        // Broadcast with bcast disabled: dropped, held across a valid gap, counted
        idle_inputs(); sof = 1'b1; data_valid = 1'b1; data_in = 64'h0000_FFFF_FFFF_FFFF;
        tick();
        check_val("t2.da", da_addr, 48'hFFFF_FFFF_FFFF);
        idle_inputs(); data_valid = 1'b1; local_invalid = 1'b1; broad_valid = 1'b1;
        tick();
        check_decision("t2", 1, 0, 1, 1, 0, 0);
        idle_inputs(); cfg_bcast_en = 1'b1; cfg_promisc = 1'b1;
        tick();
        check_decision("t2.hold", 0, 0, 1, 1, 0, 0);
        idle_inputs(); data_valid = 1'b1; eof = 1'b1;
        tick();
        exp_cnt = 1;
        check_decision("t2.end", 0, 0, 0, 0, 0, 0);
        check_val("t2.cnt", drop_count, exp_cnt);

        // Broadcast with bcast enabled: accepted
        idle_inputs(); sof = 1'b1; data_valid = 1'b1; data_in = 64'h0000_FFFF_FFFF_FFFF;
        tick();
        idle_inputs(); data_valid = 1'b1; local_invalid = 1'b1; broad_valid = 1'b1; cfg_bcast_en = 1'b1;
        tick();
        check_decision("t2b", 1, 1, 0, 1, 0, 0);
        idle_inputs(); data_valid = 1'b1; eof = 1'b1;
        tick();

        // Pause multicast with mcast enabled: accepted
        idle_inputs(); sof = 1'b1; data_valid = 1'b1; data_in = 64'h0000_0100_00C2_8001;
        tick();
        check_val("t3.da", da_addr, 48'h0180_C200_0001);
        idle_inputs(); data_valid = 1'b1; local_invalid = 1'b1; multi_valid = 1'b1; cfg_mcast_en = 1'b1;
        tick();
        check_decision("t3", 1, 1, 0, 0, 1, 0);
        idle_inputs(); data_valid = 1'b1; eof = 1'b1;
        tick();

        // Abort: second sof four cycles after the first, no eof in between
        idle_inputs(); sof = 1'b1; data_valid = 1'b1; data_in = 64'h0000_0605_0403_0201;
        tick();
        idle_inputs(); data_valid = 1'b1; local_invalid = 1'b1;
        tick();
        check_decision("t4.first", 1, 0, 1, 0, 0, 0);
        idle_inputs(); data_valid = 1'b1;
        tick();
        tick();
        idle_inputs(); sof = 1'b1; data_valid = 1'b1; data_in = 64'h0000_CCDD_EEFF_AABB;
        tick();
        exp_cnt = 2;
        check_decision("t4.abort", 0, 0, 0, 0, 0, 1);
        check_val("t4.da", da_addr, 48'hBBAA_FFEE_DDCC);
        idle_inputs(); data_valid = 1'b1;
        tick();
        check_decision("t4.new", 1, 1, 0, 0, 0, 0);
        check_val("t4.cnt", drop_count, exp_cnt);
        idle_inputs(); data_valid = 1'b1; eof = 1'b1;
        tick();

        // Single-word frame: decision for exactly one cycle, then a sof is not an abort
        idle_inputs(); sof = 1'b1; eof = 1'b1; data_valid = 1'b1; data_in = 64'h1;
        tick();
        idle_inputs();
        tick();
        check_decision("t5", 1, 1, 0, 0, 0, 0);
        tick();
        check_decision("t5.gone", 0, 0, 0, 0, 0, 0);
        sof = 1'b1; data_valid = 1'b1; data_in = 64'h2;
        tick();
        check_val("t5.noabort", frame_abort, 1'b0);
        idle_inputs(); data_valid = 1'b1; eof = 1'b1;
        tick();
        tick();

        // Reset mid-frame clears everything and the tail of the frame is ignored
        idle_inputs(); sof = 1'b1; data_valid = 1'b1; data_in = 64'h0000_0F0E_0D0C_0B0A;
        tick();
        idle_inputs(); data_valid = 1'b1; local_invalid = 1'b1;
        tick();
        reset = 1'b1; idle_inputs(); data_valid = 1'b1;
        tick();
        reset = 1'b0;
        check_decision("t7.rst", 0, 0, 0, 0, 0, 0);
        check_val("t7.da", da_addr, 48'h0);
        check_val("t7.cnt", drop_count, 0);
        idle_inputs(); data_valid = 1'b1; eof = 1'b1; local_invalid = 1'b1;
        tick();
        idle_inputs();
        tick();
        check_decision("t7.tail", 0, 0, 0, 0, 0, 0);

        // Saturation: count to max-1, then three more drops, then clear against a drop
        for (int k = 0; k < CMAX - 1; k++) send_single(1'b1, 1'b0);
        check_val("t6.pre", drop_count, CMAX - 1);
        send_single(1'b1, 1'b0);
        check_val("t6.sat1", drop_count, CMAX);
        send_single(1'b1, 1'b0);
        check_val("t6.sat2", drop_count, CMAX);
        send_single(1'b1, 1'b0);
        check_val("t6.sat3", drop_count, CMAX);
        send_single(1'b0, 1'b0);
        check_val("t6.accept", drop_count, CMAX);
        send_single(1'b1, 1'b1);
        check_val("t6.clr", drop_count, 0);

        // Random frames against the timeline model
        build_random(ncyc);
        do_reset();
        for (int i = 0; i < ncyc; i++) begin
            check_val($sformatf("rnd%0d.da", i),    da_addr,        ex[i].da);
            check_val($sformatf("rnd%0d.cv", i),    da_check_valid, ex[i].cv);
            check_val($sformatf("rnd%0d.acc", i),   frame_accept,   ex[i].acc);
            check_val($sformatf("rnd%0d.drop", i),  frame_drop,     ex[i].drp);
            check_val($sformatf("rnd%0d.bcast", i), frame_is_bcast, ex[i].bc);
            check_val($sformatf("rnd%0d.mcast", i), frame_is_mcast, ex[i].mc);
            check_val($sformatf("rnd%0d.abort", i), frame_abort,    ex[i].ab);
            if (!ex[i].inc) check_val($sformatf("rnd%0d.cnt", i), drop_count, ecnt[i]);
            sof           = st[i].sof;
            eof           = st[i].eof;
            data_valid    = st[i].dv;
            data_in       = st[i].data;
            local_invalid = st[i].li;
            broad_valid   = st[i].bv;
            multi_valid   = st[i].mv;
            cfg_promisc   = st[i].pr;
            cfg_bcast_en  = st[i].bce;
            cfg_mcast_en  = st[i].mce;
            clr_count     = st[i].clr;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
